// File: rtl/trap_sequencer.sv
// trap_sequencer: serialises trap-entry / MRET CSR updates through the single CSR write port, then redirects fetch.
// Latency: acceptance to busy low is 5 cycles for trap entry (6 with TRAP_MTVAL_EN), 4 for MRET, with redirectReady high.
// Backpressure: redirectValid/redirectPC held until redirectReady; busy stalls the pipeline throughout. Optional: `define TRAP_MTVAL_EN.
module trap_sequencer #(
  parameter logic [31:0] INT_CAUSE   = 32'h8000000B,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        trapRequest,
  input  logic [31:0] trapCause,
  input  logic [31:0] trapPC,
  input  logic [31:0] trapValue,
  input  logic        mretRequest,
  input  logic [31:0] interruptPC,
  input  logic [11:0] coreDestinationCSR,
  input  logic [11:0] coreReadCSR,
  input  logic [31:0] coreWriteData,
  input  logic        coreDestinationEnable,
  output logic [11:0] destinationCSR,
  output logic [11:0] readCSR,
  output logic [31:0] csrWriteData,
  output logic        csrDestinationEnable,
  input  logic [31:0] csrReadData,
  input  logic [31:0] trapVector,
  output logic        busy,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  input  logic        redirectReady
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_STATUS,
    S_M_STATUS,
    S_M_EPC,
    S_REDIRECT
`ifdef TRAP_MTVAL_EN
    , S_T_VAL
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        is_int_q, is_int_d;
  logic [31:0] target_q, target_d;
  logic        mie_shadow_q, mie_shadow_d;
  logic        busy_q, busy_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] vector_base;
`ifdef TRAP_MTVAL_EN
  logic [31:0] tval_q, tval_d;
`else
  logic        unused_trap_value;
  assign unused_trap_value = ^trapValue;
`endif

  assign vector_base   = trapVector & ~32'h3;
  assign busy          = busy_q;
  assign redirectValid = redirect_valid_q;
  assign redirectPC    = target_q;

  // Next-state, latch updates and the CSR port mux (passthrough when idle, sequencer-owned otherwise)
  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    is_int_d         = is_int_q;
    target_d         = target_q;
    mie_shadow_d     = mie_shadow_q;
    busy_d           = busy_q;
    redirect_valid_d = redirect_valid_q;
`ifdef TRAP_MTVAL_EN
    tval_d           = tval_q;
`endif
    destinationCSR       = 12'h000;
    readCSR              = 12'h000;
    csrWriteData         = 32'h0;
    csrDestinationEnable = 1'b0;

    case (state_q)
      S_IDLE: begin
        destinationCSR       = coreDestinationCSR;
        readCSR              = coreReadCSR;
        csrWriteData         = coreWriteData;
        csrDestinationEnable = coreDestinationEnable;
        // Track MSTATUS.MIE so interrupts can be gated without a CSR read port
        if (coreDestinationEnable && coreDestinationCSR == CSR_MSTATUS)
          mie_shadow_d = coreWriteData[3];
        if (trapRequest) begin
          cause_d  = trapCause;
          epc_d    = trapPC;
          is_int_d = 1'b0;
`ifdef TRAP_MTVAL_EN
          tval_d   = trapValue;
`endif
          state_d  = S_T_EPC;
          busy_d   = 1'b1;
        end else if (mretRequest) begin
          state_d  = S_M_STATUS;
          busy_d   = 1'b1;
        end else if (interrupt && mie_shadow_q) begin
          cause_d  = INT_CAUSE;
          epc_d    = interruptPC;
          is_int_d = 1'b1;
`ifdef TRAP_MTVAL_EN
          tval_d   = 32'h0;
`endif
          state_d  = S_T_EPC;
          busy_d   = 1'b1;
        end
      end
      S_T_EPC: begin
        destinationCSR       = CSR_MEPC;
        csrWriteData         = epc_q;
        csrDestinationEnable = 1'b1;
        state_d              = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        destinationCSR       = CSR_MCAUSE;
        csrWriteData         = cause_q;
        csrDestinationEnable = 1'b1;
`ifdef TRAP_MTVAL_EN
        state_d              = S_T_VAL;
`else
        state_d              = S_T_STATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      S_T_VAL: begin
        destinationCSR       = CSR_MTVAL;
        csrWriteData         = tval_q;
        csrDestinationEnable = 1'b1;
        state_d              = S_T_STATUS;
      end
`endif
      S_T_STATUS: begin
        // MPP<=M, MPIE<=MIE, MIE<=0; target from MTVEC (vectored offset only for interrupts)
        readCSR              = CSR_MSTATUS;
        destinationCSR       = CSR_MSTATUS;
        csrWriteData         = {csrReadData[31:13], 2'b11, csrReadData[10:8], csrReadData[3],
                                csrReadData[6:4], 1'b0, csrReadData[2:0]};
        csrDestinationEnable = 1'b1;
        mie_shadow_d         = 1'b0;
        if (VECTORED_EN && is_int_q && trapVector[1:0] == 2'b01)
          target_d = vector_base + {cause_q[29:0], 2'b00};
        else
          target_d = vector_base;
        redirect_valid_d     = 1'b1;
        state_d              = S_REDIRECT;
      end
      S_M_STATUS: begin
        // MIE<=MPIE, MPIE<=1; MPP left as is
        readCSR              = CSR_MSTATUS;
        destinationCSR       = CSR_MSTATUS;
        csrWriteData         = {csrReadData[31:8], 1'b1, csrReadData[6:4], csrReadData[7],
                                csrReadData[2:0]};
        csrDestinationEnable = 1'b1;
        mie_shadow_d         = csrReadData[7];
        state_d              = S_M_EPC;
      end
      S_M_EPC: begin
        readCSR          = CSR_MEPC;
        target_d         = csrReadData & ~32'h3;
        redirect_valid_d = 1'b1;
        state_d          = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirectReady) begin
          redirect_valid_d = 1'b0;
          busy_d           = 1'b0;
          state_d          = S_IDLE;
        end
      end
      default: begin
        redirect_valid_d = 1'b0;
        busy_d           = 1'b0;
        state_d          = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset abandons any sequence in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      cause_q          <= 32'h0;
      epc_q            <= 32'h0;
      is_int_q         <= 1'b0;
      target_q         <= 32'h0;
      mie_shadow_q     <= 1'b0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
`ifdef TRAP_MTVAL_EN
      tval_q           <= 32'h0;
`endif
    end else begin
      state_q          <= state_d;
      cause_q          <= cause_d;
      epc_q            <= epc_d;
      is_int_q         <= is_int_d;
      target_q         <= target_d;
      mie_shadow_q     <= mie_shadow_d;
      busy_q           <= busy_d;
      redirect_valid_q <= redirect_valid_d;
`ifdef TRAP_MTVAL_EN
      tval_q           <= tval_d;
`endif
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: drives trap_sequencer with directed and random trap/MRET/interrupt traffic.
// A CSR file is emulated here; expected CSR writes and redirects are queued and compared by a monitor.
// Build with +define+TRAP_MTVAL_EN to cover the MTVAL variant.
`timescale 1ns/1ps
module tb_trap_sequencer;

  localparam logic [11:0] MSTATUS  = 12'h300;
  localparam logic [11:0] MTVEC    = 12'h305;
  localparam logic [11:0] MSCRATCH = 12'h340;
  localparam logic [11:0] MEPC     = 12'h341;
  localparam logic [11:0] MCAUSE   = 12'h342;
  localparam logic [11:0] MTVAL    = 12'h343;
  localparam logic [31:0] INT_CAUSE = 32'h8000000B;
  localparam bit          VEC_EN    = 1'b1;
`ifdef TRAP_MTVAL_EN
  localparam int LAT_TRAP = 6;
`else
  localparam int LAT_TRAP = 5;
`endif
  localparam int LAT_MRET = 4;

  logic        clock, reset, interrupt, trapRequest, mretRequest;
  logic [31:0] trapCause, trapPC, trapValue, interruptPC, coreWriteData;
  logic [11:0] coreDestinationCSR, coreReadCSR, destinationCSR, readCSR;
  logic        coreDestinationEnable, csrDestinationEnable;
  logic [31:0] csrWriteData, csrReadData, trapVector, redirectPC;
  logic        busy, redirectValid, redirectReady;

  trap_sequencer #(.INT_CAUSE(INT_CAUSE), .VECTORED_EN(VEC_EN)) dut (
    .clock(clock), .reset(reset), .interrupt(interrupt),
    .trapRequest(trapRequest), .trapCause(trapCause), .trapPC(trapPC), .trapValue(trapValue),
    .mretRequest(mretRequest), .interruptPC(interruptPC),
    .coreDestinationCSR(coreDestinationCSR), .coreReadCSR(coreReadCSR),
    .coreWriteData(coreWriteData), .coreDestinationEnable(coreDestinationEnable),
    .destinationCSR(destinationCSR), .readCSR(readCSR), .csrWriteData(csrWriteData),
    .csrDestinationEnable(csrDestinationEnable), .csrReadData(csrReadData),
    .trapVector(trapVector), .busy(busy), .redirectValid(redirectValid),
    .redirectPC(redirectPC), .redirectReady(redirectReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Emulated CSR file: combinational read, write on the clock edge
  logic [31:0] csr_mem [0:4095];
  always @(posedge clock) if (csrDestinationEnable) csr_mem[destinationCSR] <= csrWriteData;
  assign csrReadData = csr_mem[readCSR];
  assign trapVector  = csr_mem[MTVEC];

  typedef struct packed { logic redir; logic [11:0] addr; logic [31:0] data; } ev_t;
  ev_t         exp_q[$];
  logic [31:0] m_csr [0:4095];
  bit          m_mie;
  int          n_cmp = 0, n_bad = 0;
  int          hold_low = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] last_redir_pc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void exp_write(input logic [11:0] a, input logic [31:0] d);
    exp_q.push_back('{redir: 1'b0, addr: a, data: d});
    m_csr[a] = d;
  endfunction

  // Reference trap entry: record PC and cause, save MIE into MPIE, disable interrupts, previous mode M
  function automatic void push_trap(input bit is_int, input logic [31:0] cause,
                                    input logic [31:0] epc, input logic [31:0] tval);
    logic [31:0] st, tgt;
    exp_write(MEPC, epc);
    exp_write(MCAUSE, cause);
`ifdef TRAP_MTVAL_EN
    exp_write(MTVAL, is_int ? 32'h0 : tval);
`else
    if (tval == 32'h0) tgt = 32'h0;
`endif
    st = m_csr[MSTATUS];
    st[7] = st[3];
    st[3] = 1'b0;
    st[12:11] = 2'b11;
    exp_write(MSTATUS, st);
    tgt = m_csr[MTVEC] & ~32'h3;
    if (is_int && VEC_EN && (m_csr[MTVEC] & 32'h3) == 32'h1) tgt = tgt + cause * 4;
    exp_q.push_back('{redir: 1'b1, addr: 12'h0, data: tgt});
    m_mie = 1'b0;
  endfunction

  // Reference MRET: MIE gets MPIE, MPIE set, return to MEPC word-aligned
  function automatic void push_mret();
    logic [31:0] st;
    bit old_mpie;
    st = m_csr[MSTATUS];
    old_mpie = st[7];
    st[3] = st[7];
    st[7] = 1'b1;
    exp_write(MSTATUS, st);
    exp_q.push_back('{redir: 1'b1, addr: 12'h0, data: m_csr[MEPC] & ~32'h3});
    m_mie = old_mpie;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (hold_low > 0) begin
      redirectReady = 1'b0;
      if (redirectValid) hold_low--;
    end else if (rand_ready) redirectReady = ($urandom_range(0, 3) != 0);
    else redirectReady = 1'b1;
  endtask

  task automatic wait_idle(input string nm, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 300) begin
      tick();
      cyc++;
    end
    check({"idle_", nm}, {31'h0, busy}, 32'h0);
  endtask

  task automatic core_write(input logic [11:0] a, input logic [31:0] d);
    exp_write(a, d);
    if (a == MSTATUS) m_mie = d[3];
    coreDestinationCSR = a; coreWriteData = d; coreDestinationEnable = 1'b1;
    tick();
    coreDestinationEnable = 1'b0;
  endtask

  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] val,
                         input bit cw, input logic [11:0] cw_a, input logic [31:0] cw_d, input bit all_req);
    int  cyc;
    bit  timed;
    timed = !rand_ready && hold_low == 0;
    if (cw) begin
      exp_write(cw_a, cw_d);
      if (cw_a == MSTATUS) m_mie = cw_d[3];
      coreDestinationCSR = cw_a; coreWriteData = cw_d; coreDestinationEnable = cw;
    end
    push_trap(1'b0, cause, pc, val);
    trapRequest = 1'b1; trapCause = cause; trapPC = pc; trapValue = val;
    if (all_req) begin mretRequest = 1'b1; interrupt = 1'b1; end
    tick();
    trapRequest = 1'b0; mretRequest = 1'b0; interrupt = 1'b0; coreDestinationEnable = 1'b0;
    check("busy_after_trap_accept", {31'h0, busy}, 32'h1);
    wait_idle("trap", cyc);
    if (timed) check("trap_latency", 32'(cyc + 1), 32'(LAT_TRAP));
  endtask

  task automatic do_mret();
    int cyc;
    bit timed;
    timed = !rand_ready && hold_low == 0;
    push_mret();
    mretRequest = 1'b1;
    tick();
    mretRequest = 1'b0;
    check("busy_after_mret_accept", {31'h0, busy}, 32'h1);
    wait_idle("mret", cyc);
    if (timed) check("mret_latency", 32'(cyc + 1), 32'(LAT_MRET));
  endtask

  task automatic do_irq(input logic [31:0] pc);
    int cyc;
    push_trap(1'b1, INT_CAUSE, pc, 32'h0);
    interrupt = 1'b1; interruptPC = pc;
    tick();
    interrupt = 1'b0;
    check("busy_after_irq_accept", {31'h0, busy}, 32'h1);
    wait_idle("irq", cyc);
  endtask

  // Core enables MIE while the interrupt line is already high: taken on the following cycle
  task automatic enable_and_take(input logic [31:0] pc);
    int cyc;
    exp_write(MSTATUS, 32'h8);
    m_mie = 1'b1;
    push_trap(1'b1, INT_CAUSE, pc, 32'h0);
    interrupt = 1'b1; interruptPC = pc;
    coreDestinationCSR = MSTATUS; coreWriteData = 32'h8; coreDestinationEnable = 1'b1;
    tick();
    coreDestinationEnable = 1'b0;
    check("busy_in_enable_cycle", {31'h0, busy}, 32'h0);
    tick();
    check("busy_after_enabled_irq", {31'h0, busy}, 32'h1);
    interrupt = 1'b0;
    wait_idle("enabled_irq", cyc);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 3))
      0: pick_addr = MSTATUS;
      1: pick_addr = MTVEC;
      2: pick_addr = MEPC;
      default: pick_addr = MSCRATCH;
    endcase
  endfunction

  // Monitor: pops an expectation for every CSR write and every redirect handshake
  initial begin : monitor
    ev_t  e;
    logic prev_hs;
    prev_hs = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) prev_hs = 1'b0;
      else begin
        if (prev_hs) begin
          check("busy_after_handshake", {31'h0, busy}, 32'h0);
          check("valid_after_handshake", {31'h0, redirectValid}, 32'h0);
        end
        prev_hs = 1'b0;
        if (csrDestinationEnable) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write @%0t: csr %h <= %h, none expected", $time, destinationCSR, csrWriteData);
          end else begin
            e = exp_q.pop_front();
            check("write_is_not_redirect", {31'h0, e.redir}, 32'h0);
            check("write_addr", {20'h0, destinationCSR}, {20'h0, e.addr});
            check("write_data", csrWriteData, e.data);
          end
        end
        if (redirectValid) begin
          check("busy_during_redirect", {31'h0, busy}, 32'h1);
          if (exp_q.size() == 0 || !exp_q[0].redir) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_redirect @%0t: pc %h, no redirect expected next", $time, redirectPC);
          end else if (redirectReady) begin
            e = exp_q.pop_front();
            check("redirect_pc", redirectPC, e.data);
            last_redir_pc = redirectPC;
            prev_hs = 1'b1;
          end else begin
            check("redirect_pc_stable", redirectPC, exp_q[0].data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations outstanding", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] r, d, saved_cause;
    logic [11:0] a;
    m_mie = 1'b0;
    reset = 1'b0; interrupt = 1'b0; trapRequest = 1'b0; mretRequest = 1'b0;
    trapCause = 32'h0; trapPC = 32'h0; trapValue = 32'h0; interruptPC = 32'h0;
    coreDestinationCSR = 12'h0; coreReadCSR = 12'h0; coreWriteData = 32'h0;
    coreDestinationEnable = 1'b0; redirectReady = 1'b1;
    repeat (3) tick();
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_redirect_valid", {31'h0, redirectValid}, 32'h0);
    check("reset_redirect_pc", redirectPC, 32'h0);
    check("reset_csr_we", {31'h0, csrDestinationEnable}, 32'h0);
    reset = 1'b1;
    tick();

    core_write(MSCRATCH, 32'h0); core_write(MTVAL, 32'h0); core_write(MCAUSE, 32'h0);
    core_write(MEPC, 32'h0); core_write(MTVEC, 32'h100); core_write(MSTATUS, 32'h1808);

    // Exception
    do_trap(32'h2, 32'h40, 32'h77, 1'b0, 12'h0, 32'h0, 1'b0);
    check("exc_mepc", csr_mem[MEPC], 32'h40);
    check("exc_mcause", csr_mem[MCAUSE], 32'h2);
    check("exc_mstatus", csr_mem[MSTATUS], 32'h1880);
    check("exc_redirect", last_redir_pc, 32'h100);

    // MRET
    core_write(MSTATUS, 32'h1880); core_write(MEPC, 32'h44);
    do_mret();
    check("mret_mstatus", csr_mem[MSTATUS], 32'h1888);
    check("mret_redirect", last_redir_pc, 32'h44);

    // Masked interrupt, then enabled by a core MSTATUS write (vectored MTVEC)
    core_write(MTVEC, 32'h201); core_write(MSTATUS, 32'h0);
    interrupt = 1'b1; interruptPC = 32'h84;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("masked_irq_busy", {31'h0, busy}, 32'h0);
    end
    enable_and_take(32'h84);
    check("irq_mepc", csr_mem[MEPC], 32'h84);
    check("irq_mcause", csr_mem[MCAUSE], 32'h8000000B);
    check("irq_redirect", last_redir_pc, 32'h22C);

    // All requests at once, redirect stalled three cycles; interrupt stays pending
    core_write(MSTATUS, 32'h8);
    hold_low = 3;
    do_trap(32'h7, 32'h300, 32'h55, 1'b0, 12'h0, 32'h0, 1'b1);
    check("combo_mcause", csr_mem[MCAUSE], 32'h7);
    check("combo_redirect", last_redir_pc, 32'h200);
    interrupt = 1'b1; interruptPC = 32'h90;
    repeat (5) begin
      tick();
      check("pending_irq_masked", {31'h0, busy}, 32'h0);
    end
    enable_and_take(32'h90);
    check("pending_irq_redirect", last_redir_pc, 32'h22C);

    // Reset while MCAUSE is being written
    saved_cause = m_csr[MCAUSE];
    exp_write(MEPC, 32'h1000);
    trapRequest = 1'b1; trapCause = 32'h5; trapPC = 32'h1000;
    tick();
    trapRequest = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_mie = 1'b0;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_valid", {31'h0, redirectValid}, 32'h0);
    check("midreset_pc", redirectPC, 32'h0);
    check("midreset_csr_we", {31'h0, csrDestinationEnable}, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("midreset_mcause_kept", csr_mem[MCAUSE], saved_cause);
    core_write(MSCRATCH, 32'hABCD);

    // Randomised traffic with random redirect backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0: begin
          a = pick_addr();
          r = $urandom;
          d = (a == MTVEC) ? ((r & ~32'h3) | 32'($urandom_range(0, 1))) : r;
          core_write(a, d);
        end
        1, 2: begin
          a = pick_addr();
          r = $urandom;
          do_trap($urandom, $urandom, $urandom, ($urandom_range(0, 2) == 0), a, r, 1'b0);
        end
        3: if (m_mie) do_irq($urandom);
           else begin r = $urandom; core_write(MSTATUS, r | 32'h8); end
        4: do_mret();
        default: do_trap($urandom, $urandom, $urandom, 1'b0, 12'h0, 32'h0, 1'b1);
      endcase
    end
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
